biu_mux: RTL and testbench
==========================

# biu_mux

Parametrised bus interface unit between the CPU data port and NSLV memory-mapped slaves (DMEM plus peripherals). Decodes each request against per-slave base/mask windows, forwards it to exactly one slave, waits for that slave's acknowledge and returns registered read data with a ready/error handshake. Replaces the fixed two-way combinational split. Adds unmapped-address errors and a bounded-wait timeout.

## Interface
- NSLV, 4, number of slave ports (1..8)
- SLV_BASE, {32'h0005_0000, 32'h0004_0000, 32'h0003_4560, 32'h0000_0000}, packed 32*NSLV base addresses, slave i in bits [32i+31:32i]
- SLV_MASK, {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_0000}, packed 32*NSLV match masks
- TIMEOUT, 16, WAIT cycles without ack before error (>=2)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- dreq  in  1  CPU request valid; held until dready
- daddr  in  32  CPU byte address
- dwdata  in  32  CPU write data
- dwe  in  4  CPU byte write enables; 0 = read
- drdata  out  32  registered read data
- dready  out  1  one-cycle completion pulse
- derr  out  1  error flag, valid with dready
- s_daddr  out  32  latched address to all slaves
- s_dwdata  out  32  latched write data to all slaves
- s_dwe  out  4*NSLV  write enables, nonzero only for the selected slave
- s_sel  out  NSLV  one-hot slave select
- s_drdata  in  32*NSLV  slave read data
- s_ack  in  NSLV  slave acknowledge; may be combinational from s_sel

## Operation
- Match: hit[i] = ((daddr & SLV_MASK[i]) == SLV_BASE[i]); several hits -> lowest index wins.
- FSM states IDLE, WAIT, RESP.
- IDLE: on dreq=1 latch daddr, dwdata, dwe and slave index. Any hit -> WAIT; no hit -> RESP with derr=1, drdata=0.
- WAIT: s_sel[idx]=1, s_dwe[4idx+3:4idx]=latched dwe, other lanes 0. s_daddr/s_dwdata = latched values, stable for the whole transaction.
- In WAIT, s_ack[idx]=1 -> capture s_drdata[idx] into drdata, derr=0, go RESP. Acks from unselected slaves are ignored.
- Write transactions complete the same way; drdata captures whatever the slave returns.
- Timeout counter clears on entry to WAIT and increments each WAIT cycle without ack. If it reaches TIMEOUT-1 with no ack -> RESP, derr=1, drdata=0.
- Ack on the same cycle the count reaches the limit: ack wins.
- RESP: dready=1 for exactly one cycle, s_sel=0, s_dwe=0, then IDLE. dreq is ignored in WAIT and RESP.
- drdata and derr hold their values until the next RESP.

## Timing
- Reset (reset=0 at a rising edge): state IDLE, drdata=0, dready=0, derr=0, s_sel=0, s_dwe=0, s_daddr=0, s_dwdata=0, counter=0.
- Reset mid-transaction abandons it. No dready is produced, and s_sel/s_dwe are 0 after that edge.
- Zero-wait slave: dreq at edge 0 accepted, WAIT during cycle 1, dready high during cycle 2 (2-cycle latency).
- Slave acking k cycles after selection: latency 2+k.
- Unmapped address: dready one cycle after acceptance (1-cycle latency).
- Timeout: dready TIMEOUT+1 cycles after acceptance.
- Back-to-back: next request accepted at the earliest in the cycle after dready (one idle cycle between transactions).
- All outputs are registered; no combinational path from dreq/daddr to any output.

## Configuration
- BIU_TIMEOUT_EN defined: timeout counter and error path as above.
- BIU_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely for ack, and derr is set only for unmapped addresses.

## Test plan
- Read 0x0000_0010, slave0 acks immediately returning 0x1234_5678 -> s_sel=0001 in cycle 1; dready=1, derr=0, drdata=0x1234_5678 in cycle 2.
- Write 0x0003_4564, dwdata=0xA5A5_A5A5, dwe=1111, slave1 acks after 3 cycles -> s_dwe=0x00F0; other lanes 0; dready at cycle 5; derr=0.
- Read 0x0009_0000 (unmapped) -> no s_sel ever; dready=1, derr=1, drdata=0 one cycle after acceptance.
- Read 0x0004_0008, slave2 never acks, BIU_TIMEOUT_EN defined -> dready with derr=1, drdata=0 exactly 17 cycles after acceptance. With the macro undefined -> no dready after 100 cycles.
- Reset asserted during WAIT on slave3 -> after that edge s_sel=0, dready=0. The next request to 0x0000_0000 completes normally.
- Ack on slave2 while slave0 selected -> ignored; completion only on slave0 ack, with slave0 data.

Source files
------------

// File: rtl/biu_mux.sv
// Bus interface unit: decodes CPU data requests onto NSLV base/mask slave windows.
// Optional bounded-wait timeout is enabled by defining BIU_TIMEOUT_EN.
module biu_mux #(
  parameter int                  NSLV     = 4,
  parameter logic [32*NSLV-1:0]  SLV_BASE = {32'h0005_0000, 32'h0004_0000, 32'h0003_4560, 32'h0000_0000},
  parameter logic [32*NSLV-1:0]  SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_0000},
  parameter int                  TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dreq,
  input  logic [31:0]          daddr,
  input  logic [31:0]          dwdata,
  input  logic [3:0]           dwe,
  output logic [31:0]          drdata,
  output logic                 dready,
  output logic                 derr,
  output logic [31:0]          s_daddr,
  output logic [31:0]          s_dwdata,
  output logic [4*NSLV-1:0]    s_dwe,
  output logic [NSLV-1:0]      s_sel,
  input  logic [32*NSLV-1:0]   s_drdata,
  input  logic [NSLV-1:0]      s_ack
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state, next_state;
  logic [IW-1:0]     idx, idx_nxt, hit_idx;
  logic              hit_any;
  logic              sel_ack;
  logic [31:0]       drdata_nxt, s_daddr_nxt, s_dwdata_nxt;
  logic              dready_nxt, derr_nxt;
  logic [4*NSLV-1:0] s_dwe_nxt;
  logic [NSLV-1:0]   s_sel_nxt;

`ifdef BIU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          expired;
  assign expired = (cnt == CW'(TIMEOUT - 1));
`endif

  assign sel_ack = s_ack[idx];

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = {IW{1'b0}};
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((daddr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end else begin
        hit_any = hit_any;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dreq) next_state = hit_any ? WAIT : RESP;
        else      next_state = IDLE;
      end
      WAIT: begin
        if (sel_ack) next_state = RESP;
`ifdef BIU_TIMEOUT_EN
        else if (expired) next_state = RESP;
`endif
        else next_state = WAIT;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of every registered output; an ack always beats the timeout.
  always_comb begin
    drdata_nxt   = drdata;
    derr_nxt     = derr;
    dready_nxt   = 1'b0;
    s_sel_nxt    = s_sel;
    s_dwe_nxt    = s_dwe;
    s_daddr_nxt  = s_daddr;
    s_dwdata_nxt = s_dwdata;
    idx_nxt      = idx;
`ifdef BIU_TIMEOUT_EN
    cnt_nxt      = cnt;
`endif
    case (state)
      IDLE: begin
        if (dreq) begin
          s_daddr_nxt  = daddr;
          s_dwdata_nxt = dwdata;
          idx_nxt      = hit_idx;
          if (hit_any) begin
            for (int i = 0; i < NSLV; i++) begin
              s_sel_nxt[i]       = (hit_idx == IW'(i));
              s_dwe_nxt[4*i +: 4] = (hit_idx == IW'(i)) ? dwe : 4'h0;
            end
`ifdef BIU_TIMEOUT_EN
            cnt_nxt = {CW{1'b0}};
`endif
          end else begin
            dready_nxt = 1'b1;
            derr_nxt   = 1'b1;
            drdata_nxt = 32'h0000_0000;
          end
        end else begin
          dready_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (sel_ack) begin
          drdata_nxt = s_drdata[32*idx +: 32];
          derr_nxt   = 1'b0;
          dready_nxt = 1'b1;
          s_sel_nxt  = {NSLV{1'b0}};
          s_dwe_nxt  = {(4*NSLV){1'b0}};
        end
`ifdef BIU_TIMEOUT_EN
        else if (expired) begin
          drdata_nxt = 32'h0000_0000;
          derr_nxt   = 1'b1;
          dready_nxt = 1'b1;
          s_sel_nxt  = {NSLV{1'b0}};
          s_dwe_nxt  = {(4*NSLV){1'b0}};
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`else
        else begin
          dready_nxt = 1'b0;
        end
`endif
      end
      RESP:    dready_nxt = 1'b0;
      default: dready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drdata   <= 32'h0000_0000;
      dready   <= 1'b0;
      derr     <= 1'b0;
      s_sel    <= {NSLV{1'b0}};
      s_dwe    <= {(4*NSLV){1'b0}};
      s_daddr  <= 32'h0000_0000;
      s_dwdata <= 32'h0000_0000;
      idx      <= {IW{1'b0}};
`ifdef BIU_TIMEOUT_EN
      cnt      <= {CW{1'b0}};
`endif
    end else begin
      drdata   <= drdata_nxt;
      dready   <= dready_nxt;
      derr     <= derr_nxt;
      s_sel    <= s_sel_nxt;
      s_dwe    <= s_dwe_nxt;
      s_daddr  <= s_daddr_nxt;
      s_dwdata <= s_dwdata_nxt;
      idx      <= idx_nxt;
`ifdef BIU_TIMEOUT_EN
      cnt      <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_biu_mux.sv
// Scoreboard bench for biu_mux: a stimulus process queues expected responses and a
// negedge monitor checks slave-side selects and every dready against the queue.
module tb_biu_mux;

  localparam int NEVER = 1000;
  localparam int TMO   = 16;
  localparam logic [31:0] BASE [4] = '{32'h0000_0000, 32'h0003_4560, 32'h0004_0000, 32'h0005_0000};
  localparam logic [31:0] MASK [4] = '{32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000};

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] exp_data;
    logic        exp_err;
    int          lat;
    int          acc;
    bit          abandon;
  } item_t;

  logic         clk = 1'b0;
  logic         reset, dreq;
  logic [31:0]  daddr, dwdata;
  logic [3:0]   dwe;
  logic [31:0]  drdata;
  logic         dready, derr;
  logic [31:0]  s_daddr, s_dwdata;
  logic [15:0]  s_dwe;
  logic [3:0]   s_sel;
  logic [127:0] s_drdata;
  logic [3:0]   s_ack;

  logic [31:0] sdata [4];
  int          dly [4];
  int          sel_cnt = 0;
  logic [3:0]  spur = 4'h0;
  int          cyc = 0;
  int          rdy_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  item_t       q [$];

  biu_mux dut (
    .clk(clk), .reset(reset), .dreq(dreq), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .dready(dready), .derr(derr), .s_daddr(s_daddr), .s_dwdata(s_dwdata),
    .s_dwe(s_dwe), .s_sel(s_sel), .s_drdata(s_drdata), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    sel_cnt <= (s_sel == 4'h0) ? 0 : sel_cnt + 1;
  end

  // Slaves: a selected slave acks once selected for dly cycles; unselected ones ack at random.
  assign s_drdata = {sdata[3], sdata[2], sdata[1], sdata[0]};
  always_comb begin
    for (int i = 0; i < 4; i++)
      s_ack[i] = s_sel[i] ? (sel_cnt >= dly[i]) : spur[i];
  end
  always @(negedge clk) spur <= 4'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  // Monitor: slave-side signals while a slave is selected, and every completion.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (s_sel != 4'h0) begin
        if (q.size() == 0) chk("unexpected_sel", 32'(s_sel), 32'h0);
        else begin
          chk("s_sel", 32'(s_sel), (q[0].idx >= 0) ? (32'h1 << q[0].idx) : 32'h0);
          chk("s_dwe", 32'(s_dwe), (q[0].idx >= 0) ? (32'(q[0].we) << (4 * q[0].idx)) : 32'h0);
          chk("s_daddr", s_daddr, q[0].addr);
          chk("s_dwdata", s_dwdata, q[0].wdata);
        end
      end
      if (dready) begin
        rdy_cnt++;
        if (q.size() == 0 || q[0].abandon) chk("unexpected_dready", 32'h1, 32'h0);
        else begin
          item_t it;
          it = q.pop_front();
          chk("drdata", drdata, it.exp_data);
          chk("derr", 32'(derr), 32'(it.exp_err));
          chk("latency", 32'(cyc - it.acc + 1), 32'(it.lat));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input int d, input bit abandon);
    item_t it;
    bit    got;
    it.idx = ref_decode(a);
    for (int i = 0; i < 4; i++) sdata[i] = $urandom;
    if (it.idx >= 0) dly[it.idx] = d;
    it.addr = a; it.wdata = wd; it.we = we; it.abandon = abandon; it.acc = 0;
    if (it.idx < 0) begin
      it.exp_data = 32'h0; it.exp_err = 1'b1; it.lat = 1;
    end else if (d >= NEVER) begin
      it.exp_data = 32'h0; it.exp_err = 1'b1; it.lat = TMO + 1;
    end else begin
      it.exp_data = sdata[it.idx]; it.exp_err = 1'b0; it.lat = 2 + d;
    end
    q.push_back(it);
    @(negedge clk);
    dreq = 1'b1; daddr = a; dwdata = wd; dwe = we;
    @(posedge clk);
    #1 q[q.size() - 1].acc = cyc;
    if (!abandon) begin
      got = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (dready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) chk("dready_wait", 32'h0, 32'h1);
      dreq = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    dreq  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_s_sel", 32'(s_sel), 32'h0);
    chk("rst_s_dwe", 32'(s_dwe), 32'h0);
    chk("rst_dready", 32'(dready), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    if (q.size() > 0 && q[0].abandon) void'(q.pop_front());
  endtask

  initial begin
    int r0;
    reset = 1'b0; dreq = 1'b0; daddr = 32'h0; dwdata = 32'h0; dwe = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sdata[i] = 32'h0;
      dly[i]   = NEVER;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_drdata", drdata, 32'h0);
    chk("reset_dready", 32'(dready), 32'h0);
    chk("reset_derr", 32'(derr), 32'h0);
    chk("reset_s_sel", 32'(s_sel), 32'h0);
    chk("reset_s_dwe", 32'(s_dwe), 32'h0);
    chk("reset_s_daddr", s_daddr, 32'h0);
    chk("reset_s_dwdata", s_dwdata, 32'h0);
    reset = 1'b1;

    issue(32'h0000_0010, 32'h0, 4'h0, 0, 1'b0);
    issue(32'h0003_4564, 32'hA5A5_A5A5, 4'hF, 3, 1'b0);
    issue(32'h0009_0000, 32'h0, 4'h0, 0, 1'b0);
`ifdef BIU_TIMEOUT_EN
    issue(32'h0004_0008, 32'h0, 4'h0, NEVER, 1'b0);
`else
    issue(32'h0004_0008, 32'h0, 4'h0, NEVER, 1'b1);
    r0 = rdy_cnt;
    repeat (100) @(negedge clk);
    chk("no_dready_100", 32'(rdy_cnt), 32'(r0));
    do_reset();
`endif
    // Ack lands on the same cycle the wait counter would expire.
    issue(32'h0004_0010, 32'h0, 4'h0, TMO - 1, 1'b0);

    issue(32'h0005_0000, 32'h0, 4'h0, NEVER, 1'b1);
    repeat (3) @(negedge clk);
    do_reset();
    r0 = rdy_cnt;
    repeat (3) @(negedge clk);
    chk("post_reset_no_dready", 32'(rdy_cnt), 32'(r0));
    issue(32'h0000_0000, 32'h0, 4'h0, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int          s;
      int          d;
      logic [31:0] a;
      s = $urandom_range(0, 4);
      if (s == 4) a = $urandom | 32'h8000_0000;
      else        a = BASE[s] | ($urandom & ~MASK[s]);
      d = $urandom_range(0, 4);
`ifdef BIU_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) d = NEVER;
`endif
      issue(a, $urandom, 4'($urandom), d, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
